mat_result_buffer: RTL and testbench
====================================

# mat_result_buffer

Downstream capture stage for `mat_ops`. Records the row-major `result_data` element stream that `mat_ops` emits while busy, together with the result dimensions. Replays the result as a byte stream (header byte, then elements) over a valid/ready handshake toward the display/UART formatter. Also exposes a random-access read port for the on-board display.

## Interface
- `MAX_ELEMS`, 25, buffer depth; largest matrix is 5×5.
- `DATA_W`, 8, element width.
- `DIM_W`, 3, dimension width.
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `busy_flag`  in  1  from `mat_ops`; an element is valid on each cycle with `busy_flag && !op_done`.
- `op_done`  in  1  from `mat_ops`; one-cycle end-of-operation pulse.
- `error_flag`  in  1  from `mat_ops`; sampled on the `op_done` cycle.
- `result_data`  in  DATA_W  streamed element.
- `result_m`, `result_n`  in  DIM_W  result dimensions; valid on the `op_done` cycle.
- `clr`  in  1  synchronous clear: returns to IDLE and drops any held result.
- `out_valid`  out  1  byte-stream valid.
- `out_ready`  in  1  byte-stream ready from the consumer.
- `out_data`  out  DATA_W  byte-stream data.
- `out_last`  out  1  marks the final byte of a frame.
- `rd_addr`  in  5  display read index.
- `rd_data`  out  DATA_W  buffer word at `rd_addr`, combinational; reads 0 when `rd_addr >= MAX_ELEMS`.
- `res_valid`  out  1  buffer holds a complete, error-free result.
- `res_m`, `res_n`  out  DIM_W  latched result dimensions.
- `res_err`  out  1  last operation failed (upstream error or count mismatch).
- `lost`  out  1  one-cycle pulse: an operation started while this block was in SEND and was not captured.

## Operation
- **States:** IDLE, CAPTURE, SEND, HOLD.
- **IDLE / HOLD → CAPTURE**
  - Taken on the first cycle with `busy_flag` high.
  - On entry: `wr_ptr` ← 0, `res_valid` ← 0, `res_err` ← 0.
  - The element present on that entry cycle is written.
- **CAPTURE write rule**
  - Each cycle with `busy_flag && !op_done`: write `result_data` to `buf[wr_ptr]`, then increment `wr_ptr`.
  - At `wr_ptr == MAX_ELEMS`, further elements are discarded and an internal `ovf` bit is set.
- **CAPTURE end (`op_done` cycle)**
  - Latch `res_m`, `res_n`.
  - Compute `exp = result_m * result_n` (5-bit, max 25).
  - If `error_flag`, `ovf`, or `wr_ptr != exp`: set `res_err` and go to HOLD with `res_valid` = 0.
  - Otherwise go to SEND.
- **SEND frame** (`1 + exp` bytes)
  - Byte 0 is the header `{2'b00, res_m, res_n}`.
  - Bytes 1..exp are `buf[0..exp-1]`.
  - `out_last` is high with the final byte.
  - An `exp == 0` result (dimension 0) sends a header-only frame, with `out_last` on the header.
- **SEND → HOLD:** on the accepted last byte; sets `res_valid` = 1.
- **HOLD:** the buffer and `res_*` stay stable; `rd_data` is valid.
- **`busy_flag` rising during SEND:** the operation is not captured, `lost` pulses for one cycle, and SEND completes normally.
- **`clr`:** highest priority in every state. Goes to IDLE and clears `res_valid`, `res_err`, `out_valid`, `ovf` and `wr_ptr`. Buffer contents are not zeroed.

## Timing
- **Reset values:** all outputs 0, state IDLE, `wr_ptr` 0, buffer words 0.
- **Capture:** one element per clock, no backpressure toward `mat_ops`.
- **Header latency:** `out_valid` rises on the cycle after the `op_done` cycle.
- **Handshake:**
  - A byte transfers on a rising edge with `out_valid && out_ready`.
  - Once raised, `out_valid`, `out_data` and `out_last` hold until accepted.
  - The next byte is presented on the following cycle, so with `out_ready` tied high a frame takes `1 + exp` consecutive cycles.
- **`out_valid`** never depends combinationally on `out_ready`.
- **Reset mid-frame:** `out_valid` drops asynchronously; no partial frame resumes.
- **`rd_data`:** combinational from registered storage. During CAPTURE it reflects partially written data and is not valid.

## Structure
- Shared package `mat_pkg`:
  - `MAX_ELEMS`, `DATA_W`, `DIM_W`.
  - State enum/localparams for IDLE/CAPTURE/SEND/HOLD.
  - Header-packing function `hdr(m, n)`.
- Sub-module `mat_buf_regfile`:
  - 25×8 register array with a synchronous write port and an asynchronous read port.
  - Instanced once; its read port is muxed between the SEND pointer and `rd_addr` by duplicated read logic (two read ports).
- The remainder is the FSM plus two 5-bit pointers (`wr_ptr`, `tx_ptr`).

## Test plan
- **Scalar result, free-flowing:** stream 2,4,…,18 (3×3), `op_done`, `out_ready` = 1 → frame 0x1B,2,4,…,18; `out_last` on 18; 10 consecutive cycles; `res_valid` = 1; `rd_addr` = 4 gives 10.
- **Backpressure:** same stream, `out_ready` toggling 1-0-0-1 → every byte held stable while stalled, with no loss or duplication.
- **Error path:** `error_flag` = 1 at `op_done` → no `out_valid`, `res_err` = 1, `res_valid` = 0.
- **Count mismatch:** 8 elements for a 3×3 result → `res_err` = 1, no frame.
- **Overflow:** 27 elements with a 5×5 result → `res_err` = 1, no frame.
- **Collision:** `busy_flag` rises mid-SEND with `out_ready` = 0 → one `lost` pulse, and the original frame completes intact.
- **Async reset:** assert `rst_n` = 0 mid-CAPTURE → all outputs 0 immediately, then the next operation captures correctly.

Source files
------------

// File: rtl/mat_pkg.sv
// rtl/mat_pkg.sv - shared constants, state encoding and helpers for the result buffer
package mat_pkg;

  localparam int MAX_ELEMS = 25;
  localparam int DATA_W    = 8;
  localparam int DIM_W     = 3;
  localparam int PTR_W     = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_SEND    = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

  function automatic logic [DATA_W-1:0] hdr(input logic [DIM_W-1:0] m,
                                            input logic [DIM_W-1:0] n);
    return {2'b00, m, n};
  endfunction

  // Dimensions never exceed 5, so the 5-bit product cannot wrap.
  function automatic logic [PTR_W-1:0] elem_count(input logic [DIM_W-1:0] m,
                                                   input logic [DIM_W-1:0] n);
    return PTR_W'(m) * PTR_W'(n);
  endfunction

endpackage

// File: rtl/mat_result_buffer_if.sv
// rtl/mat_result_buffer_if.sv - outbound byte-stream handshake bundle
interface mat_result_buffer_if;
  import mat_pkg::*;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (output out_valid, output out_data, output out_last, input out_ready);
  modport slave  (input out_valid, input out_data, input out_last, output out_ready);

endinterface

// File: rtl/mat_buf_regfile.sv
// rtl/mat_buf_regfile.sv - 25x8 element store, one sync write port, two async read ports
module mat_buf_regfile
  import mat_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [PTR_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [PTR_W-1:0]  i_raddr_a,
  output logic [DATA_W-1:0] o_rdata_a,
  input  logic [PTR_W-1:0]  i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_b
);

  logic [DATA_W-1:0] r_mem [MAX_ELEMS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_ELEMS; i++) r_mem[i] <= '0;
    end else if (i_we && (i_waddr < PTR_W'(MAX_ELEMS))) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Out-of-range indices read as zero rather than aliasing.
  assign o_rdata_a = (i_raddr_a < PTR_W'(MAX_ELEMS)) ? r_mem[i_raddr_a] : '0;
  assign o_rdata_b = (i_raddr_b < PTR_W'(MAX_ELEMS)) ? r_mem[i_raddr_b] : '0;

endmodule

// File: rtl/mat_result_buffer.sv
// rtl/mat_result_buffer.sv - captures the mat_ops result stream and replays it as a framed byte stream
module mat_result_buffer
  import mat_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_busy_flag,
  input  logic              i_op_done,
  input  logic              i_error_flag,
  input  logic [DATA_W-1:0] i_result_data,
  input  logic [DIM_W-1:0]  i_result_m,
  input  logic [DIM_W-1:0]  i_result_n,
  input  logic              i_clr,
  mat_result_buffer_if.master o_out,
  input  logic [PTR_W-1:0]  i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_res_valid,
  output logic [DIM_W-1:0]  o_res_m,
  output logic [DIM_W-1:0]  o_res_n,
  output logic              o_res_err,
  output logic              o_lost
);

  state_t            r_state, w_next;
  logic [PTR_W-1:0]  r_wr_ptr, r_tx_ptr, r_exp, w_cnt, w_exp;
  logic              r_ovf, r_skip, r_busy_d, r_lost;
  logic              r_res_valid, r_res_err, r_out_valid, r_out_last;
  logic [DATA_W-1:0] r_out_data, w_tx_word;
  logic [DIM_W-1:0]  r_res_m, r_res_n;
  logic              w_start, w_cap, w_elem, w_we, w_end, w_fail, w_fire;

  // r_skip keeps an operation that began during SEND from being half-captured afterwards.
  assign w_start = ((r_state == ST_IDLE) || (r_state == ST_HOLD)) && i_busy_flag && !r_skip;
  assign w_cap   = w_start || (r_state == ST_CAPTURE);
  assign w_cnt   = w_start ? '0 : r_wr_ptr;
  assign w_elem  = w_cap && i_busy_flag && !i_op_done;
  assign w_we    = w_elem && (w_cnt < PTR_W'(MAX_ELEMS));
  assign w_end   = w_cap && i_op_done;
  assign w_exp   = elem_count(i_result_m, i_result_n);
  assign w_fail  = i_error_flag || (r_ovf && !w_start) || (w_cnt != w_exp);
  assign w_fire  = (r_state == ST_SEND) && r_out_valid && o_out.out_ready;

  mat_buf_regfile u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_we      (w_we),
    .i_waddr   (w_cnt),
    .i_wdata   (i_result_data),
    .i_raddr_a (r_tx_ptr),
    .o_rdata_a (w_tx_word),
    .i_raddr_b (i_rd_addr),
    .o_rdata_b (o_rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_HOLD: if (w_start) w_next = ST_CAPTURE;
      ST_SEND:          if (w_fire && r_out_last) w_next = ST_HOLD;
      default:          ;
    endcase
    if (w_end) w_next = w_fail ? ST_HOLD : ST_SEND;
    if (i_clr) w_next = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_tx_ptr    <= '0;
      r_exp       <= '0;
      r_ovf       <= 1'b0;
      r_skip      <= 1'b0;
      r_busy_d    <= 1'b0;
      r_lost      <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_err   <= 1'b0;
      r_res_m     <= '0;
      r_res_n     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      r_busy_d <= i_busy_flag;
      r_lost   <= (r_state == ST_SEND) && i_busy_flag && !r_busy_d && !i_clr;
      if (i_clr) begin
        r_wr_ptr    <= '0;
        r_ovf       <= 1'b0;
        r_skip      <= 1'b0;
        r_res_valid <= 1'b0;
        r_res_err   <= 1'b0;
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end else begin
        if ((r_state == ST_SEND) && i_busy_flag) r_skip <= 1'b1;
        else if (!i_busy_flag)                   r_skip <= 1'b0;
        if (w_start) begin
          r_res_valid <= 1'b0;
          r_res_err   <= 1'b0;
          r_ovf       <= 1'b0;
        end
        if (w_cap)            r_wr_ptr <= w_cnt + PTR_W'(w_we);
        if (w_elem && !w_we)  r_ovf    <= 1'b1;
        if (w_end) begin
          r_res_m <= i_result_m;
          r_res_n <= i_result_n;
          r_exp   <= w_exp;
          if (w_fail) begin
            r_res_err <= 1'b1;
          end else begin
            r_out_valid <= 1'b1;
            r_out_data  <= hdr(i_result_m, i_result_n);
            r_out_last  <= (w_exp == '0);
            r_tx_ptr    <= '0;
          end
        end
        // Accepted byte: present the next element, or close the frame.
        if (w_fire) begin
          if (r_out_last) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_res_valid <= 1'b1;
          end else begin
            r_out_data <= w_tx_word;
            r_out_last <= ((r_tx_ptr + 5'd1) == r_exp);
            r_tx_ptr   <= r_tx_ptr + 5'd1;
          end
        end
      end
    end
  end

  assign o_out.out_valid = r_out_valid;
  assign o_out.out_data  = r_out_data;
  assign o_out.out_last  = r_out_last;
  assign o_res_valid     = r_res_valid;
  assign o_res_err       = r_res_err;
  assign o_res_m         = r_res_m;
  assign o_res_n         = r_res_n;
  assign o_lost          = r_lost;

endmodule

// File: tb/tb_mat_result_buffer.sv
// tb/tb_mat_result_buffer.sv - self-checking bench for mat_result_buffer
module tb_mat_result_buffer;
  import mat_pkg::*;

  typedef struct {
    int m;
    int n;
    int cnt;
    bit err;
    int mode;
    bit x_valid;
    bit x_err;
    int x_len;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       busy = 1'b0, op_done = 1'b0, err_in = 1'b0, clr = 1'b0;
  logic [7:0] rdata_in = '0;
  logic [2:0] m_in = '0, n_in = '0;
  logic [4:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic       res_valid, res_err, lost;
  logic [2:0] res_m, res_n;

  mat_result_buffer_if u_if();

  mat_result_buffer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_busy_flag  (busy),
    .i_op_done    (op_done),
    .i_error_flag (err_in),
    .i_result_data(rdata_in),
    .i_result_m   (m_in),
    .i_result_n   (n_in),
    .i_clr        (clr),
    .o_out        (u_if),
    .i_rd_addr    (rd_addr),
    .o_rd_data    (rd_data),
    .o_res_valid  (res_valid),
    .o_res_m      (res_m),
    .o_res_n      (res_n),
    .o_res_err    (res_err),
    .o_lost       (lost)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] model_mem [MAX_ELEMS];
  logic [7:0] stim [32];
  logic [7:0] exp_q [$];
  vec_t       vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one operation and builds the expected frame from the result rules.
  task automatic run_op(input int m, input int n, input int cnt, input bit err);
    for (int i = 0; i < cnt; i++) begin
      busy = 1'b1;
      rdata_in = stim[i];
      tick();
    end
    busy = 1'b1; op_done = 1'b1; err_in = err;
    m_in = 3'(m); n_in = 3'(n); rdata_in = 8'hEE;
    tick();
    busy = 1'b0; op_done = 1'b0; err_in = 1'b0;
    for (int i = 0; i < cnt && i < MAX_ELEMS; i++) model_mem[i] = stim[i];
    exp_q.delete();
    if (!err && cnt == m * n) begin
      exp_q.push_back(8'(m * 8 + n));
      for (int i = 0; i < m * n; i++) exp_q.push_back(stim[i]);
    end
  endtask

  task automatic collect(input int mode, input bit collide, output int got_len);
    logic [7:0] got [$];
    bit         gl [$];
    bit         stall = 1'b0, done = 1'b0;
    logic [7:0] hd = '0;
    logic       hl = 1'b0;
    int         lost_n = 0, last_cyc = -1;
    check("hdr_latency", u_if.out_valid, exp_q.size() != 0);
    for (int c = 0; c < 200 && !done; c++) begin
      if (mode == 0)      u_if.out_ready = 1'b1;
      else if (mode == 1) u_if.out_ready = (c % 4 == 0) || (c % 4 == 3);
      else if (mode == 2) u_if.out_ready = 1'($urandom_range(0, 1));
      else                u_if.out_ready = (c >= 12);
      if (collide) begin
        busy = (c >= 2 && c <= 5);
        op_done = (c == 5);
        rdata_in = 8'($urandom);
        m_in = 3'd2; n_in = 3'd2;
      end
      if (stall) begin
        check("hold_valid", u_if.out_valid, 1);
        check("hold_data", u_if.out_data, hd);
        check("hold_last", u_if.out_last, hl);
      end
      if (u_if.out_valid && u_if.out_ready) begin
        got.push_back(u_if.out_data);
        gl.push_back(u_if.out_last);
        if (u_if.out_last) begin
          done = 1'b1;
          last_cyc = c;
        end
      end
      stall = u_if.out_valid && !u_if.out_ready;
      hd = u_if.out_data;
      hl = u_if.out_last;
      tick();
      if (lost === 1'b1) lost_n++;
    end
    busy = 1'b0; op_done = 1'b0; u_if.out_ready = 1'b0;
    got_len = got.size();
    check("frame_len", got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      check("frame_byte", got[i], exp_q[i]);
      check("frame_last", gl[i], i == got.size() - 1);
    end
    if (mode == 0 && exp_q.size() != 0) check("frame_cycles", last_cyc + 1, exp_q.size());
    check("lost_pulses", lost_n, collide);
  endtask

  task automatic check_rd(input int a);
    rd_addr = 5'(a);
    #1;
    check("rd_data", rd_data, (a < MAX_ELEMS) ? model_mem[a] : 8'd0);
  endtask

  initial begin
    int got_len;
    u_if.out_ready = 1'b0;
    for (int i = 0; i < MAX_ELEMS; i++) model_mem[i] = '0;

    vecs[0] = '{3, 3, 9,  1'b0, 0, 1'b1, 1'b0, 10};
    vecs[1] = '{3, 3, 9,  1'b0, 1, 1'b1, 1'b0, 10};
    vecs[2] = '{3, 3, 9,  1'b1, 0, 1'b0, 1'b1, 0};
    vecs[3] = '{3, 3, 8,  1'b0, 0, 1'b0, 1'b1, 0};
    vecs[4] = '{5, 5, 27, 1'b0, 0, 1'b0, 1'b1, 0};
    vecs[5] = '{5, 5, 25, 1'b0, 0, 1'b1, 1'b0, 26};
    vecs[6] = '{0, 3, 0,  1'b0, 0, 1'b1, 1'b0, 1};
    vecs[7] = '{1, 1, 1,  1'b0, 1, 1'b1, 1'b0, 2};
    vecs[8] = '{2, 4, 8,  1'b0, 2, 1'b1, 1'b0, 9};

    repeat (3) tick();
    check("rst_out_valid", u_if.out_valid, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_err", res_err, 0);
    check("rst_lost", lost, 0);
    check("rst_res_m", res_m, 0);
    check_rd(3);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 32; i++) stim[i] = 8'(2 * (i + 1));
    for (int v = 0; v < 9; v++) begin
      run_op(vecs[v].m, vecs[v].n, vecs[v].cnt, vecs[v].err);
      collect(vecs[v].mode, 1'b0, got_len);
      check("tbl_len", got_len, vecs[v].x_len);
      check("tbl_res_valid", res_valid, vecs[v].x_valid);
      check("tbl_res_err", res_err, vecs[v].x_err);
      check("tbl_res_m", res_m, vecs[v].m);
      check("tbl_res_n", res_n, vecs[v].n);
      check_rd(4);
    end

    // Collision: a second operation arrives while the first frame is stalled.
    run_op(3, 3, 9, 1'b0);
    collect(3, 1'b1, got_len);
    check("coll_res_valid", res_valid, 1);
    check("coll_res_m", res_m, 3);
    check_rd(8);

    // Async reset in the middle of a capture.
    rd_addr = 5'd1;
    for (int i = 0; i < 4; i++) begin
      busy = 1'b1;
      rdata_in = 8'hA0 + 8'(i);
      tick();
    end
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", u_if.out_valid, 0);
    check("arst_res_m", res_m, 0);
    check("arst_res_n", res_n, 0);
    check("arst_rd_data", rd_data, 0);
    busy = 1'b0;
    for (int i = 0; i < MAX_ELEMS; i++) model_mem[i] = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    run_op(3, 3, 9, 1'b0);
    collect(0, 1'b0, got_len);
    check("post_rst_valid", res_valid, 1);
    check_rd(4);

    // Clear from HOLD drops the result but keeps the buffer words.
    clr = 1'b1; tick(); clr = 1'b0;
    check("clr_res_valid", res_valid, 0);
    check_rd(4);
    // Clear mid-frame kills the frame outright.
    run_op(2, 2, 4, 1'b0);
    check("clr_pre_valid", u_if.out_valid, 1);
    clr = 1'b1; tick(); clr = 1'b0;
    check("clr_out_valid", u_if.out_valid, 0);
    u_if.out_ready = 1'b1;
    tick(); tick();
    check("clr_no_resume", u_if.out_valid, 0);
    u_if.out_ready = 1'b0;

    for (int r = 0; r < 20; r++) begin
      int m, n, e, sel, cnt;
      bit err;
      m = $urandom_range(0, 5);
      n = $urandom_range(0, 5);
      e = m * n;
      sel = $urandom_range(0, 7);
      cnt = (sel == 0) ? e + 1 : (sel == 1 && e > 0) ? e - 1 : (sel == 2) ? 27 : e;
      err = (sel == 3);
      for (int i = 0; i < 32; i++) stim[i] = 8'($urandom);
      run_op(m, n, cnt, err);
      collect(2, 1'b0, got_len);
      check("rnd_res_valid", res_valid, exp_q.size() != 0);
      check("rnd_res_err", res_err, exp_q.size() == 0);
      check("rnd_res_m", res_m, m);
      check("rnd_res_n", res_n, n);
      check_rd($urandom_range(0, 31));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
